mmcm_drp_reconfig_mc: RTL
=========================

Name: mmcm_drp_reconfig_mc

Overview:
Multi-channel successor to the single-MMCM DRP reconfiguration engine. It reprograms one of NUM_CH MMCM_ADV/PLL_ADV primitives from a bank-selected config ROM using read-modify-write over the DRP port. Compared with the single-channel engine it adds:
- per-channel reset and lock tracking
- DRP address-width generalisation
- drdy and lock timeouts
- a done/error status interface

It sits between the clocking control CSRs and the clock primitives.

Parameters:
- NUM_CH, 2: number of MMCM/PLL instances driven.
- RSEL_WIDTH, 2: ROM bank-select width.
- CONFIG_COUNT, 23: max ROM entries per bank.
- ADDR_WIDTH, $clog2(CONFIG_COUNT): ROM address width.
- DADDR_W, 7: DRP address width (7 for MMCM/PLL).
- DRDY_TMO, 1023: cycles allowed between den and drdy.
- LOCK_TMO, 65535: cycles allowed for locked after rst_mmcm release.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous active-high reset.
- rom_sel  out  RSEL_WIDTH  ROM bank select.
- rom_addr  out  ADDR_WIDTH  ROM entry address.
- rom_data  in  DADDR_W+32  {daddr, keep-mask[31:16], set-bits[15:0]}; valid ≤2 cycles after rom_addr/rom_sel change.
- s_chan  in  $clog2(NUM_CH) (min 1)  target channel.
- s_baddr  in  RSEL_WIDTH  ROM bank.
- s_count  in  ADDR_WIDTH  number of entries minus 1.
- s_valid  in  1  request valid.
- s_ready  out  1  engine idle and accepting.
- done  out  1  one-cycle pulse at end of a request.
- err  out  1  sticky error; cleared on next accepted request.
- err_code  out  2  0 none, 1 drdy timeout, 2 lock timeout, 3 verify mismatch.
- dout  in  16*NUM_CH  per-channel DRP read data.
- drdy  in  NUM_CH  per-channel DRP ready.
- locked  in  NUM_CH  per-channel lock.
- den  out  NUM_CH  per-channel DRP enable; one-hot or zero.
- dwe  out  1  shared write enable.
- daddr  out  DADDR_W  shared DRP address.
- din  out  16  shared DRP write data.
- rst_mmcm  out  NUM_CH  per-channel primitive reset.

Behaviour:
- Reset values:
  - rst_mmcm all 1.
  - den, dwe, s_ready, done, err all 0; err_code 0.
  - daddr, din, rom_addr 0.
  - state INIT.
- Clock domain and registration: one clock; all outputs registered.
- States: INIT, WAIT_LOCK, IDLE, ADDRESS, WAIT_A_DRDY, BITMASK, BITSEL, WRITE, WAIT_DRDY, (VERIFY, WAIT_V_DRDY), RELOCK.
- INIT: release all rst_mmcm, load lock timer, go to WAIT_LOCK next cycle.
- WAIT_LOCK: wait for &locked.
  - Timer expiry: err=1, code 2, go to IDLE anyway.
- IDLE: s_ready=1.
  - On s_valid&&s_ready:
    - latch chan, bank and count; rom_addr=0; err cleared.
    - rst_mmcm[chan]=1 (others untouched).
    - s_ready drops the next cycle; go to ADDRESS.
- ADDRESS: daddr<=rom_data[DADDR_W+31:32]; den[chan]<=1 (read).
- WAIT_A_DRDY: wait for drdy[chan]; den falls the cycle after drdy.
- BITMASK: din<=keep-mask & dout[chan].
- BITSEL: din<=din | set-bits; rom_addr+1.
- WRITE: den[chan]=1, dwe=1.
- WAIT_DRDY: on drdy[chan], den and dwe fall.
  - count≠0: count−1, go to ADDRESS.
  - count=0: go to RELOCK (or VERIFY when enabled).
- RELOCK:
  - Release rst_mmcm[chan]; wait for locked[chan] with LOCK_TMO.
  - Success: done pulse, go to IDLE.
  - Timeout: err, code 2, done pulse, go to IDLE.
- DRP timeout (any den wait): counter reloads on each den rise.
  - On expiry: den=0, dwe=0, err, code 1, release rst_mmcm[chan], done pulse, go to IDLE (no RELOCK).
- drdy handling:
  - drdy on a non-selected channel, or drdy with den low, is ignored.
  - drdy in the same cycle as timer expiry counts as success.
- Channel range: s_chan ≥ NUM_CH → request accepted, immediate err code 1, done pulse, nothing driven.
- Reset mid-operation: everything returns to reset values; all rst_mmcm reassert, then re-lock via INIT.
- Count arithmetic: s_count wraps nothing; rom_addr increments exactly s_count+1 times per request.

Optional Feature:
MMCM_DRP_VERIFY_EN
- Defined: after each WRITE completes, the engine re-reads the same daddr (VERIFY/WAIT_V_DRDY) and compares dout[chan] with din.
  - Mismatch: err=1, code 3; the sequence continues to completion.
  - Each entry costs one extra DRP read.
- Undefined: the VERIFY states are absent; code 3 is never produced.

Test Plan:
- Reset released, locked=2'b11 after 10 cycles → rst_mmcm=00 one cycle after reset; s_ready=1 within 12 cycles; err=0.
- s_chan=1, s_baddr=2, s_count=2; ROM entry0={7'h08,16'h1000,16'h0145}; dout=16'hFFFF, drdy 2 cycles after den → rst_mmcm[1]=1 and rst_mmcm[0]=0 throughout; 3 writes issued; first write daddr=08, din=16'h1145; done pulse; s_ready returns.
- drdy never asserted, DRDY_TMO=15 → den falls 16 cycles after rising; err_code=1; rst_mmcm[chan] released; done pulse.
- locked[0] held low after reconfig, LOCK_TMO=100 → err_code=2 after 101 cycles in RELOCK; s_ready=1.
- reset pulsed during WAIT_DRDY → den=0, dwe=0, rst_mmcm=all 1 next cycle, state INIT.
- MMCM_DRP_VERIFY_EN: readback returns 16'h0000 vs din 16'h1145 → err_code=3; all entries still written; done pulse.

Source files
------------

// File: rtl/mmcm_drp_reconfig_mc.sv
// Multi-channel MMCM/PLL DRP reconfiguration engine: ROM-driven read-modify-write with drdy/lock timeouts.
// Define MMCM_DRP_VERIFY_EN to add a read-back verify of every written DRP register (err_code 3 on mismatch).
module mmcm_drp_reconfig_mc #(
  parameter int NUM_CH       = 2,
  parameter int RSEL_WIDTH   = 2,
  parameter int CONFIG_COUNT = 23,
  parameter int ADDR_WIDTH   = $clog2(CONFIG_COUNT),
  parameter int DADDR_W      = 7,
  parameter int DRDY_TMO     = 1023,
  parameter int LOCK_TMO     = 65535,
  localparam int CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                  clk,
  input  logic                  reset,
  output logic [RSEL_WIDTH-1:0] rom_sel,
  output logic [ADDR_WIDTH-1:0] rom_addr,
  input  logic [DADDR_W+31:0]   rom_data,
  input  logic [CH_W-1:0]       s_chan,
  input  logic [RSEL_WIDTH-1:0] s_baddr,
  input  logic [ADDR_WIDTH-1:0] s_count,
  input  logic                  s_valid,
  output logic                  s_ready,
  output logic                  done,
  output logic                  err,
  output logic [1:0]            err_code,
  input  logic [16*NUM_CH-1:0]  dout,
  input  logic [NUM_CH-1:0]     drdy,
  input  logic [NUM_CH-1:0]     locked,
  output logic [NUM_CH-1:0]     den,
  output logic                  dwe,
  output logic [DADDR_W-1:0]    daddr,
  output logic [15:0]           din,
  output logic [NUM_CH-1:0]     rst_mmcm
);
  localparam int TMR_MAX = (DRDY_TMO > LOCK_TMO) ? DRDY_TMO : LOCK_TMO;
  localparam int TMR_W   = $clog2(TMR_MAX + 1);
  localparam logic [TMR_W-1:0] DRDY_LOAD = TMR_W'(DRDY_TMO);
  localparam logic [TMR_W-1:0] LOCK_LOAD = TMR_W'(LOCK_TMO);
  localparam logic [1:0] ERR_DRDY = 2'd1;
  localparam logic [1:0] ERR_LOCK = 2'd2;
`ifdef MMCM_DRP_VERIFY_EN
  localparam logic [1:0] ERR_VERIFY = 2'd3;
`endif

  typedef enum logic [3:0] {
    INIT, WAIT_LOCK, IDLE, ADDRESS, WAIT_A_DRDY, BITMASK, BITSEL, WRITE, WAIT_DRDY,
`ifdef MMCM_DRP_VERIFY_EN
    VERIFY, WAIT_V_DRDY,
`endif
    RELOCK
  } state_t;

  state_t                state;
  logic [CH_W-1:0]       chan;
  logic [ADDR_WIDTH-1:0] cnt;
  logic [TMR_W-1:0]      tmr;
  logic                  rom_wait;
  logic [15:0]           rdata;
  logic [15:0]           dout_arr [NUM_CH];
  logic [15:0]           dout_ch;
  logic                  drdy_ch;
  logic [NUM_CH-1:0]     chan_oh;
  logic [31:0]           chan_ext;

  always_comb begin
    for (int i = 0; i < NUM_CH; i++) dout_arr[i] = dout[16*i +: 16];
  end

  assign dout_ch  = dout_arr[chan];
  // drdy only counts for the selected channel while its den is outstanding
  assign drdy_ch  = drdy[chan] & den[chan];
  assign chan_oh  = NUM_CH'(1) << chan;
  assign chan_ext = 32'(s_chan);

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= INIT;
      rst_mmcm <= '1;
      den      <= '0;
      dwe      <= 1'b0;
      s_ready  <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
      err_code <= 2'd0;
      daddr    <= '0;
      din      <= '0;
      rom_addr <= '0;
      rom_sel  <= '0;
      chan     <= '0;
      cnt      <= '0;
      tmr      <= '0;
      rom_wait <= 1'b0;
      rdata    <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        INIT: begin
          rst_mmcm <= '0;
          tmr      <= LOCK_LOAD;
          state    <= WAIT_LOCK;
        end
        WAIT_LOCK: begin
          if (&locked) begin
            s_ready <= 1'b1;
            state   <= IDLE;
          end else if (tmr == '0) begin
            err      <= 1'b1;
            err_code <= ERR_LOCK;
            s_ready  <= 1'b1;
            state    <= IDLE;
          end else begin
            tmr <= tmr - TMR_W'(1);
          end
        end
        IDLE: begin
          if (s_valid && s_ready) begin
            err      <= 1'b0;
            err_code <= 2'd0;
            if (chan_ext >= 32'(NUM_CH)) begin
              err      <= 1'b1;
              err_code <= ERR_DRDY;
              done     <= 1'b1;
            end else begin
              chan           <= s_chan;
              rom_sel        <= s_baddr;
              rom_addr       <= '0;
              cnt            <= s_count;
              rst_mmcm[s_chan] <= 1'b1;
              // first ROM word needs an extra cycle after the bank/address change
              rom_wait       <= 1'b1;
              s_ready        <= 1'b0;
              state          <= ADDRESS;
            end
          end
        end
        ADDRESS: begin
          if (rom_wait) begin
            rom_wait <= 1'b0;
          end else begin
            daddr <= rom_data[DADDR_W+31:32];
            den   <= chan_oh;
            dwe   <= 1'b0;
            tmr   <= DRDY_LOAD;
            state <= WAIT_A_DRDY;
          end
        end
        BITMASK: begin
          din   <= rom_data[31:16] & rdata;
          state <= BITSEL;
        end
        BITSEL: begin
          din      <= din | rom_data[15:0];
          rom_addr <= rom_addr + ADDR_WIDTH'(1);
          state    <= WRITE;
        end
        WRITE: begin
          den   <= chan_oh;
          dwe   <= 1'b1;
          tmr   <= DRDY_LOAD;
          state <= WAIT_DRDY;
        end
`ifdef MMCM_DRP_VERIFY_EN
        VERIFY: begin
          den   <= chan_oh;
          dwe   <= 1'b0;
          tmr   <= DRDY_LOAD;
          state <= WAIT_V_DRDY;
        end
`endif
        WAIT_A_DRDY, WAIT_DRDY
`ifdef MMCM_DRP_VERIFY_EN
        , WAIT_V_DRDY
`endif
        : begin
          if (drdy_ch) begin
            den <= '0;
            dwe <= 1'b0;
            case (state)
              WAIT_A_DRDY: begin
                rdata <= dout_ch;
                state <= BITMASK;
              end
`ifdef MMCM_DRP_VERIFY_EN
              WAIT_DRDY: state <= VERIFY;
              default: begin
                if (dout_ch != din) begin
                  err      <= 1'b1;
                  err_code <= ERR_VERIFY;
                end
                if (cnt != '0) begin
                  cnt   <= cnt - ADDR_WIDTH'(1);
                  state <= ADDRESS;
                end else begin
                  rst_mmcm[chan] <= 1'b0;
                  tmr            <= LOCK_LOAD;
                  state          <= RELOCK;
                end
              end
`else
              default: begin
                if (cnt != '0) begin
                  cnt   <= cnt - ADDR_WIDTH'(1);
                  state <= ADDRESS;
                end else begin
                  rst_mmcm[chan] <= 1'b0;
                  tmr            <= LOCK_LOAD;
                  state          <= RELOCK;
                end
              end
`endif
            endcase
          end else if (tmr == '0) begin
            // abandon the request; the primitive is released without waiting for lock
            den            <= '0;
            dwe            <= 1'b0;
            err            <= 1'b1;
            err_code       <= ERR_DRDY;
            rst_mmcm[chan] <= 1'b0;
            done           <= 1'b1;
            s_ready        <= 1'b1;
            state          <= IDLE;
          end else begin
            tmr <= tmr - TMR_W'(1);
          end
        end
        RELOCK: begin
          if (locked[chan]) begin
            done    <= 1'b1;
            s_ready <= 1'b1;
            state   <= IDLE;
          end else if (tmr == '0) begin
            err      <= 1'b1;
            err_code <= ERR_LOCK;
            done     <= 1'b1;
            s_ready  <= 1'b1;
            state    <= IDLE;
          end else begin
            tmr <= tmr - TMR_W'(1);
          end
        end
        default: state <= INIT;
      endcase
    end
  end
endmodule
